alu_flags_pipe: RTL and testbench
=================================

// Module: alu_flags_pipe
// PURPOSE
//  Parametrised, pipelined multi-op ALU with five status flags: sign, zero, carry, even parity and
//  signed overflow. Adds subtract, carry-chained ADC/SBC and bitwise ops, plus a stored carry and a
//  sticky overflow. Valid/ready on both sides; sits between an operand source and a result consumer.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operand/op offered
//  in_ready   out  1      block accepts when in_valid & in_ready
//  op         in   3      000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 PASS (Z=X)
//  x, y       in   WIDTH  operands (two's complement for V)
//  out_valid  out  1      result/flags held valid
//  out_ready  in   1      consumer takes result when out_valid & out_ready
//  z          out  WIDTH  result
//  sign, zero, carry, parity, overflow  out 1 each  flags for z
//  carry_q    out  1      stored carry used by ADC/SBC
//  ovf_sticky out  1      set by any overflow=1 result; cleared by flag_clr
//  flag_clr   in   1      clears carry_q and ovf_sticky
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): s1_valid=0, s2_valid=0, out_valid=0, z=0, all flags=0,
//    carry_q=0, ovf_sticky=0; in-flight ops are dropped. in_ready=1 in the first cycle after reset.
//  - Two stages. S1 registers {op,x,y}. S2 holds the computed result and flags, driving the outputs.
//    Compute happens on the S1->S2 transfer. Latency: accept at edge N -> out_valid at edge N+2
//    with no stall.
//  - Ready chain: s2_rdy = ~s2_valid | out_ready; s1_rdy = ~s1_valid | s2_rdy; in_ready = s1_rdy.
//    Full throughput of 1 op/clk with out_ready=1. Outputs are stable while out_valid & ~out_ready.
//  - Arithmetic uses a (WIDTH+1)-bit sum:
//    ADD {c,z}=x+y. ADC {c,z}=x+y+carry_q. SUB {c,z}=x+~y+1. SBC {c,z}=x+~y+carry_q.
//    c is carry-out, so for SUB c=1 means no borrow (x>=y unsigned).
//  - Logic and PASS ops: carry=0, overflow=0.
//  - Flags: sign=z[W-1]; zero=~|z; parity=~^z (1 = even count of ones);
//    overflow = (a[W-1]==b[W-1]) & (z[W-1]!=a[W-1]), with a=x and b=y for ADD/ADC, b=~y for SUB/SBC.
//  - carry_q is updated to c only on an S1->S2 transfer of an ADD/ADC/SUB/SBC op; logic ops leave it
//    unchanged. Ops compute strictly in order, so back-to-back ADC chains see the preceding op's carry.
//  - flag_clr with no arithmetic transfer that cycle: carry_q<=0, ovf_sticky<=0.
//    Same cycle as an arithmetic transfer: the op uses the old carry_q, and the new c is written
//    (write beats clear). ovf_sticky<=overflow of that op (set beats clear).
//  - ovf_sticky goes to 1 on the transfer that produces overflow=1 and holds until flag_clr or reset.
//  - Wrap-around: results are truncated to WIDTH bits; the carry holds bit WIDTH.
//    No X-propagation beyond the data path.
// TESTING (WIDTH=16)
//  1 ADD x=FFFF y=0001, out_ready=1 -> 2 clk later: z=0000 zero=1 carry=1 parity=1 sign=0
//    overflow=0, carry_q=1.
//  2 ADD 7FFF+0001 -> z=8000 sign=1 overflow=1 parity=0 carry=0, ovf_sticky=1.
//    Next op SUB 0005-0003 -> z=0002 carry=1 overflow=0, and ovf_sticky stays 1.
//  3 Back-to-back ADD 0000FFFF-lo (x=FFFF y=0001) then ADC x=0000 y=0000 -> second z=0001 carry=0
//    (32-bit chain). Repeat with SUB 0000-0001 then SBC 0000-0000 -> z=FFFF, then z=FFFF carry=0.
//  4 Backpressure: stream 4 ADDs with out_ready=0 -> in_ready drops after 2 accepts, and z holds.
//    Raise out_ready -> results appear in order with none lost or duplicated.
//  5 flag_clr in the same cycle as an overflowing ADD -> ovf_sticky=1.
//    flag_clr alone afterwards -> carry_q=0 and ovf_sticky=0. XOR 00FF^0F0F -> z=0FF0 carry=0, carry_q kept.
//  6 Assert rst_n=0 with both stages full -> next clk: out_valid=0, flags/carry_q/ovf_sticky=0,
//    in_ready=1, and no stale result emerges.

Source files
------------

// File: rtl/alu_flags_pipe.sv
// ---------------------------------------------------------------------------
// alu_flags_pipe
//   Two-stage pipelined ALU with status flags, a stored carry for
//   multi-word ADC/SBC chains and a sticky signed-overflow flag.
//
//   Stage 1 registers the accepted {op, x, y}. The result is computed
//   combinationally from stage 1 and captured into stage 2 on the S1->S2
//   transfer. Stage 2 drives z and the flags.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (op, x, y)
//   out_valid/out_ready result handshake (z + flags)
//   op                  000 ADD, 001 ADC, 010 SUB, 011 SBC,
//                       100 AND, 101 OR,  110 XOR, 111 PASS
//   z                   result
//   sign, zero, carry, parity, overflow   flags of z
//   carry_q             stored carry consumed by ADC/SBC
//   ovf_sticky          set by any overflowing result, cleared by flag_clr
//   flag_clr            clears carry_q and ovf_sticky
//   s1_busy, s2_busy    stage occupancy, exposed for checkers
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. A producer holds valid and its payload stable until the transfer;
// ready may depend combinationally on the downstream ready, never on valid.
// While out_valid & ~out_ready the outputs do not change.
// ---------------------------------------------------------------------------
module alu_flags_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow,
    output logic             carry_q,
    output logic             ovf_sticky,
    input  logic             flag_clr,
    output logic             s1_busy,
    output logic             s2_busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Stage 1 registers
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;

    // Stage 2 occupancy
    logic             s2_valid;

    // Ready chain
    logic s2_rdy;
    logic s1_rdy;
    logic accept;
    logic xfer;

    assign s2_rdy   = ~s2_valid | out_ready;
    assign s1_rdy   = ~s1_valid | s2_rdy;
    assign in_ready = s1_rdy;
    assign accept   = in_valid & s1_rdy;
    assign xfer     = s1_valid & s2_rdy;

    assign out_valid = s2_valid;
    assign s1_busy   = s1_valid;
    assign s2_busy   = s2_valid;

    // Combinational compute from stage 1
    logic             c_arith;
    logic [WIDTH-1:0] c_b;
    logic             c_cin;
    logic [WIDTH:0]   c_sum;
    logic [WIDTH-1:0] c_z;
    logic             c_carry;
    logic             c_ovf;

    always_comb begin
        c_arith = ~s1_op[2];
        // SUB/SBC add the inverted subtrahend; op[1] selects subtraction
        c_b     = s1_op[1] ? ~s1_y : s1_y;
        c_cin   = 1'b0;
        case (s1_op)
            OP_ADD:  c_cin = 1'b0;
            OP_ADC:  c_cin = carry_q;
            OP_SUB:  c_cin = 1'b1;
            OP_SBC:  c_cin = carry_q;
            default: c_cin = 1'b0;
        endcase
        c_sum = {1'b0, s1_x} + {1'b0, c_b} + {{WIDTH{1'b0}}, c_cin};

        c_z = '0;
        case (s1_op)
            OP_AND:  c_z = s1_x & s1_y;
            OP_OR:   c_z = s1_x | s1_y;
            OP_XOR:  c_z = s1_x ^ s1_y;
            OP_PASS: c_z = s1_x;
            default: c_z = c_sum[WIDTH-1:0];
        endcase

        c_carry = c_arith & c_sum[WIDTH];
        // Signed overflow: operands agree in sign but the result does not
        c_ovf   = c_arith & (s1_x[WIDTH-1] == c_b[WIDTH-1])
                          & (c_sum[WIDTH-1] != s1_x[WIDTH-1]);
    end

    // Stage 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= op;
                s1_x     <= x;
                s1_y     <= y;
            end else if (xfer) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 result and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            z        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (xfer) begin
                s2_valid <= 1'b1;
                z        <= c_z;
                sign     <= c_z[WIDTH-1];
                zero     <= ~|c_z;
                carry    <= c_carry;
                parity   <= ~^c_z;
                overflow <= c_ovf;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Stored carry and sticky overflow. An arithmetic transfer wins over
    // flag_clr: the new carry is written and the sticky takes this op's
    // overflow. Logic ops never overflow, so they only matter via flag_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (xfer && c_arith) begin
                carry_q <= c_carry;
                if (flag_clr) begin
                    ovf_sticky <= c_ovf;
                end else if (c_ovf) begin
                    ovf_sticky <= 1'b1;
                end
            end else if (flag_clr) begin
                carry_q    <= 1'b0;
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flags_pipe.sv
module tb_alu_flags_pipe;

    localparam int W = 16;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, flag_clr;
    logic [2:0]   op;
    logic [W-1:0] x, y, z;
    logic         sign, zero, carry, parity, overflow, carry_q, ovf_sticky;
    logic         s1_busy, s2_busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    alu_flags_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .sign(sign), .zero(zero), .carry(carry), .parity(parity),
        .overflow(overflow), .carry_q(carry_q), .ovf_sticky(ovf_sticky),
        .flag_clr(flag_clr), .s1_busy(s1_busy), .s2_busy(s2_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sign, zero, carry, parity, overflow
    task automatic chk_flags(input string tag, input logic s, input logic zr,
                             input logic c, input logic p, input logic v);
        chk({tag, ".sign"}, {31'd0, sign}, {31'd0, s});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, zr});
        chk({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
        chk({tag, ".parity"}, {31'd0, parity}, {31'd0, p});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v});
    endtask

    // Single op through an empty pipeline; result visible on return.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic clr);
        in_valid = 1'b1; op = o; x = a; y = b;
        tick();
        in_valid = 1'b0; flag_clr = clr;
        tick();
        flag_clr = 1'b0;
    endtask

    // Pops the expected result when the consumer takes one this cycle.
    task automatic take_out(input string tag);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".unexpected"}, 32'd1, 32'd0);
            end else begin
                chk(tag, {16'd0, z}, {16'd0, exp_q.pop_front()});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
        op = OP_ADD; x = '0; y = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.z", {16'd0, z}, 32'd0);
        chk_flags("rst", 0, 0, 0, 0, 0);
        chk("rst.carry_q", {31'd0, carry_q}, 32'd0);
        chk("rst.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);

        // 1: FFFF + 0001 wraps to zero with carry out
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        chk("t1.out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1.z", {16'd0, z}, 32'h0000);
        chk_flags("t1", 0, 1, 1, 1, 0);
        chk("t1.carry_q", {31'd0, carry_q}, 32'd1);
        tick();
        chk("t1.drained", {31'd0, out_valid}, 32'd0);

        // 2: signed overflow, then a clean SUB leaves the sticky set
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        chk("t2a.z", {16'd0, z}, 32'h8000);
        chk_flags("t2a", 1, 0, 0, 0, 1);
        chk("t2a.ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
        run_op(OP_SUB, 16'h0005, 16'h0003, 1'b0);
        chk("t2b.z", {16'd0, z}, 32'h0002);
        chk_flags("t2b", 0, 0, 1, 0, 0);
        chk("t2b.ovf_sticky", {31'd0, ovf_sticky}, 32'd1);

        // 3: back-to-back carry chains
        in_valid = 1'b1; op = OP_ADD; x = 16'hFFFF; y = 16'h0001;
        tick();
        op = OP_ADC; x = 16'h0000; y = 16'h0000;
        tick();
        in_valid = 1'b0;
        chk("t3a.z", {16'd0, z}, 32'h0000);
        chk("t3a.carry", {31'd0, carry}, 32'd1);
        tick();
        chk("t3b.z", {16'd0, z}, 32'h0001);
        chk("t3b.carry", {31'd0, carry}, 32'd0);
        in_valid = 1'b1; op = OP_SUB; x = 16'h0000; y = 16'h0001;
        tick();
        op = OP_SBC; x = 16'h0000; y = 16'h0000;
        tick();
        in_valid = 1'b0;
        chk("t3c.z", {16'd0, z}, 32'hFFFF);
        chk("t3c.carry", {31'd0, carry}, 32'd0);
        tick();
        chk("t3d.z", {16'd0, z}, 32'hFFFF);
        chk("t3d.carry", {31'd0, carry}, 32'd0);
        tick();

        // logic ops and PASS leave carry_q alone
        run_op(OP_AND, 16'hF0F0, 16'hFF00, 1'b0);
        chk("and.z", {16'd0, z}, 32'hF000);
        chk_flags("and", 1, 0, 0, 1, 0);
        run_op(OP_PASS, 16'h1234, 16'hFFFF, 1'b0);
        chk("pass.z", {16'd0, z}, 32'h1234);
        chk("pass.parity", {31'd0, parity}, 32'd0);
        tick();

        // 4: backpressure with four ADDs
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_ADD; x = 16'd1; y = 16'd1;
        chk("t4.rdy1", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(16'd2);
        tick();
        x = 16'd2; y = 16'd2;
        chk("t4.rdy2", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(16'd4);
        tick();
        x = 16'd3; y = 16'd3;
        chk("t4.stall", {31'd0, in_ready}, 32'd0);
        chk("t4.z_hold0", {16'd0, z}, 32'd2);
        tick(); tick();
        chk("t4.stall2", {31'd0, in_ready}, 32'd0);
        chk("t4.z_hold1", {16'd0, z}, 32'd2);
        chk("t4.out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("t4.rdy3", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(16'd6);
        take_out("t4.r1");
        tick();
        x = 16'd4; y = 16'd4;
        exp_q.push_back(16'd8);
        take_out("t4.r2");
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            take_out("t4.rn");
            tick();
        end
        chk("t4.left", exp_q.size(), 32'd0);
        chk("t4.empty", {31'd0, out_valid}, 32'd0);

        // 5: flag_clr interactions
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("t5a.carry_q", {31'd0, carry_q}, 32'd0);
        chk("t5a.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b1);
        chk("t5b.overflow", {31'd0, overflow}, 32'd1);
        chk("t5b.ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        chk("t5c.carry_q", {31'd0, carry_q}, 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("t5d.carry_q", {31'd0, carry_q}, 32'd0);
        chk("t5d.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        run_op(OP_XOR, 16'h00FF, 16'h0F0F, 1'b0);
        chk("t5e.z", {16'd0, z}, 32'h0FF0);
        chk_flags("t5e", 0, 0, 0, 1, 0);
        chk("t5e.carry_q", {31'd0, carry_q}, 32'd1);
        tick();

        // 6: reset with both stages full
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_ADD; x = 16'hFFFF; y = 16'h0001;
        tick();
        op = OP_ADD; x = 16'h1111; y = 16'h2222;
        tick();
        in_valid = 1'b0;
        chk("t6.full1", {31'd0, s1_busy}, 32'd1);
        chk("t6.full2", {31'd0, s2_busy}, 32'd1);
        chk("t6.pre_carry_q", {31'd0, carry_q}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6.out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6.z", {16'd0, z}, 32'd0);
        chk_flags("t6", 0, 0, 0, 0, 0);
        chk("t6.carry_q", {31'd0, carry_q}, 32'd0);
        chk("t6.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        chk("t6.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
